// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: merges load-use, redirect
// and multiply occupancy into stage enables, and counts stall cycles.
module pipeline_hazard_controller #(
  parameter int MUL_LATENCY  = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ID_rs,
  input  logic [3:0]  ID_rt,
  input  logic        ID_uses_rs,
  input  logic        ID_uses_rt,
  input  logic        ID_is_mul,
  input  logic        EX_mem_read,
  input  logic [3:0]  EX_rt_rd,
  input  logic        branch_redirect,
  output logic        pc_write_en,
  output logic        IF_ID_write_en,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        EX_hold,
  output logic        EX_MEM_bubble,
  output logic [15:0] stall_count
);
  typedef enum logic [1:0] {RUN, FLUSH, MUL_BUSY} state_t;

  localparam logic [3:0] MUL_INIT   = 4'(MUL_LATENCY - 1);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       lu;

  // r0 gets no exemption: a load to r0 still stalls a dependent reader.
  assign lu = EX_mem_read &&
              ((ID_uses_rs && (ID_rs == EX_rt_rd)) ||
               (ID_uses_rt && (ID_rt == EX_rt_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (branch_redirect) begin
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_INIT;
          end
        end else if (!lu && ID_is_mul) begin
          state_nxt = MUL_BUSY;
          cnt_nxt   = MUL_INIT;
        end
      end
      FLUSH, MUL_BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    pc_write_en    = 1'b0;
    IF_ID_write_en = 1'b0;
    IF_ID_flush    = 1'b0;
    ID_EX_bubble   = 1'b0;
    EX_hold        = 1'b0;
    EX_MEM_bubble  = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (branch_redirect) begin
            pc_write_en    = 1'b1;
            IF_ID_write_en = 1'b1;
            IF_ID_flush    = 1'b1;
          end else if (lu) begin
            ID_EX_bubble = 1'b1;
          end else begin
            pc_write_en    = 1'b1;
            IF_ID_write_en = 1'b1;
          end
        end
        FLUSH: begin
          pc_write_en    = 1'b1;
          IF_ID_write_en = 1'b1;
          IF_ID_flush    = 1'b1;
        end
        MUL_BUSY: begin
          EX_hold       = 1'b1;
          EX_MEM_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= 16'd0;
    else if (!pc_write_en && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; outputs are checked mid-cycle.
module tb_pipeline_hazard_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ID_rs, ID_rt, EX_rt_rd;
  logic        ID_uses_rs, ID_uses_rt, ID_is_mul, EX_mem_read, branch_redirect;
  logic        pc_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_bubble, EX_hold, EX_MEM_bubble;
  logic [15:0] stall_count;

  int tests = 0;
  int fails = 0;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, exmem_bubble}
  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_FLUSH = 6'b111000;
  localparam logic [5:0] O_LU    = 6'b000100;
  localparam logic [5:0] O_MUL   = 6'b000011;
  localparam logic [5:0] O_ZERO  = 6'b000000;

  pipeline_hazard_controller #(.MUL_LATENCY(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_is_mul(ID_is_mul), .EX_mem_read(EX_mem_read), .EX_rt_rd(EX_rt_rd),
    .branch_redirect(branch_redirect),
    .pc_write_en(pc_write_en), .IF_ID_write_en(IF_ID_write_en), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .EX_hold(EX_hold), .EX_MEM_bubble(EX_MEM_bubble),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {pc_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_bubble, EX_hold, EX_MEM_bubble};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_rs = 4'd1; ID_rt = 4'd2; EX_rt_rd = 4'd9;
    ID_uses_rs = 1'b0; ID_uses_rt = 1'b0; ID_is_mul = 1'b0;
    EX_mem_read = 1'b0; branch_redirect = 1'b0;
  endtask

  // Advance to the next mid-cycle point; inputs set afterwards apply to that cycle.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic co(input string tag, input logic [5:0] exp);
    #1 chk(tag, {10'd0, outs()}, {10'd0, exp});
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    co("reset_outs", O_ZERO);
    chk("reset_cnt", stall_count, 16'd0);

    nxt(); rst_n = 1'b1; co("release_run", O_RUN);

    // load-use on rs
    nxt(); EX_mem_read = 1'b1; EX_rt_rd = 4'd5; ID_rs = 4'd5; ID_uses_rs = 1'b1;
    co("lu_rs_stall", O_LU);
    nxt(); idle(); co("lu_rs_after", O_RUN);
    chk("lu_rs_cnt", stall_count, 16'd1);

    // load-use on rt
    nxt(); EX_mem_read = 1'b1; EX_rt_rd = 4'd7; ID_rt = 4'd7; ID_uses_rt = 1'b1;
    co("lu_rt_stall", O_LU);
    // match but rt not read: no hazard
    nxt(); ID_uses_rt = 1'b0; co("lu_unused", O_RUN);
    // r0 is not exempt
    nxt(); idle(); EX_mem_read = 1'b1; EX_rt_rd = 4'd0; ID_rs = 4'd0; ID_uses_rs = 1'b1;
    co("lu_r0_stall", O_LU);
    nxt(); idle(); co("lu_r0_after", O_RUN);
    chk("lu_r0_cnt", stall_count, 16'd3);

    // redirect: two flush cycles
    nxt(); branch_redirect = 1'b1; co("br_t0", O_FLUSH);
    nxt(); idle(); co("br_t1", O_FLUSH);
    nxt(); co("br_t2", O_RUN);
    chk("br_cnt", stall_count, 16'd3);

    // multiply, latency 4
    nxt(); ID_is_mul = 1'b1; co("mul_issue", O_RUN);
    nxt(); idle(); co("mul_b1", O_MUL);
    nxt(); co("mul_b2", O_MUL);
    nxt(); co("mul_b3", O_MUL);
    nxt(); co("mul_run", O_RUN);
    chk("mul_cnt", stall_count, 16'd6);

    // priority: redirect beats lu and mul
    nxt(); branch_redirect = 1'b1; ID_is_mul = 1'b1;
    EX_mem_read = 1'b1; EX_rt_rd = 4'd3; ID_rs = 4'd3; ID_uses_rs = 1'b1;
    co("prio_t0", O_FLUSH);
    nxt(); idle(); co("prio_t1", O_FLUSH);
    nxt(); co("prio_t2", O_RUN);
    chk("prio_cnt", stall_count, 16'd6);

    // redirect held through MUL_BUSY is deferred to the first RUN cycle
    nxt(); ID_is_mul = 1'b1; co("mbr_issue", O_RUN);
    nxt(); idle(); branch_redirect = 1'b1; co("mbr_b1", O_MUL);
    nxt(); co("mbr_b2", O_MUL);
    nxt(); co("mbr_b3", O_MUL);
    nxt(); co("mbr_run_br", O_FLUSH);
    nxt(); idle(); co("mbr_flush2", O_FLUSH);
    nxt(); co("mbr_done", O_RUN);
    chk("mbr_cnt", stall_count, 16'd9);

    // redirect in last FLUSH cycle ignored, re-accepted in RUN
    nxt(); branch_redirect = 1'b1; co("fbr_t0", O_FLUSH);
    nxt(); co("fbr_t1", O_FLUSH);
    nxt(); co("fbr_t2_accept", O_FLUSH);
    nxt(); idle(); co("fbr_t3", O_FLUSH);
    nxt(); co("fbr_t4", O_RUN);

    // reset in the 2nd MUL_BUSY cycle
    nxt(); ID_is_mul = 1'b1; co("rmul_issue", O_RUN);
    nxt(); idle(); co("rmul_b1", O_MUL);
    nxt(); co("rmul_b2_pre", O_MUL);
    rst_n = 1'b0; co("rmul_rst_outs", O_ZERO);
    chk("rmul_rst_cnt", stall_count, 16'd0);
    nxt(); rst_n = 1'b1; co("rmul_release", O_RUN);
    nxt(); co("rmul_run2", O_RUN);
    chk("rmul_cnt", stall_count, 16'd0);

    // saturation with continuous load-use
    nxt(); EX_mem_read = 1'b1; EX_rt_rd = 4'd4; ID_rt = 4'd4; ID_uses_rt = 1'b1;
    co("sat_stall", O_LU);
    for (int i = 0; i < 65540; i++) nxt();
    chk("sat_cnt", stall_count, 16'hFFFF);
    nxt(); idle(); co("sat_after", O_RUN);
    chk("sat_hold", stall_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 16-bit five-stage pipeline. It combines load-use hazards, taken-branch redirects and multi-cycle multiply occupancy into one set of stage-enable, flush and bubble controls. The controls drive the PC register, the IF/ID register, the ID/EX register and the EX stage. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- MUL_LATENCY, 4: total EX-stage cycles of a multiply, legal range 2–15.
- FLUSH_CYCLES, 2: consecutive cycles IF/ID is flushed after a redirect, legal range 1–3.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_rs, ID_rt  in  4 each  source register indices of the instruction in ID.
- ID_uses_rs, ID_uses_rt  in  1 each  ID instruction actually reads rs/rt.
- ID_is_mul  in  1  ID instruction is a multiply.
- EX_mem_read  in  1  EX instruction is a load.
- EX_rt_rd  in  4  destination register of the EX instruction.
- branch_redirect  in  1  branch/jump in ID resolved taken this cycle.
- pc_write_en  out  1  PC may update.
- IF_ID_write_en  out  1  IF/ID register may load.
- IF_ID_flush  out  1  IF/ID loads a NOP.
- ID_EX_bubble  out  1  ID/EX loads a NOP.
- EX_hold  out  1  EX stage and ID/EX hold contents (multiply in progress).
- EX_MEM_bubble  out  1  EX/MEM loads a NOP.
- stall_count  out  16  saturating count of cycles with pc_write_en=0.

## Operation
- States: RUN, FLUSH, MUL_BUSY. One down-counter cnt (4 bits) is shared by FLUSH and MUL_BUSY.
- Load-use hazard (lu): EX_mem_read and ((ID_uses_rs and ID_rs==EX_rt_rd) or (ID_uses_rt and ID_rt==EX_rt_rd)). Register 0 is not exempt.
- RUN, priority order:
  - branch_redirect: pc_write_en=1, IF_ID_flush=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN. lu and ID_is_mul are ignored that cycle.
  - lu: pc_write_en=0, IF_ID_write_en=0, ID_EX_bubble=1. Stay in RUN; the hazard clears by itself next cycle.
  - ID_is_mul: normal advance. Go to MUL_BUSY with cnt=MUL_LATENCY-1.
  - Otherwise: pc_write_en=1, IF_ID_write_en=1, all flush/bubble/hold outputs 0.
- FLUSH: pc_write_en=1, IF_ID_write_en=1, IF_ID_flush=1. All hazard inputs and branch_redirect are ignored. cnt decrements; when cnt==1, go to RUN.
- MUL_BUSY: pc_write_en=0, IF_ID_write_en=0, EX_hold=1, EX_MEM_bubble=1. lu and branch_redirect are ignored; ID is frozen, so the upstream logic re-presents them in RUN. cnt decrements; when cnt==1, go to RUN.
- In RUN, ID_EX_bubble and EX_hold are never both 1.
- stall_count increments in every cycle where pc_write_en=0 and holds at 0xFFFF.
- Reset (rst_n low, asynchronous): state=RUN, cnt=0, stall_count=0. While rst_n is low, all outputs are forced to 0, including pc_write_en and IF_ID_write_en.

## Timing
- All outputs are combinational from the current state and inputs in the same cycle. Only state, cnt and stall_count are registered.
- Redirect: IF_ID_flush is high for exactly FLUSH_CYCLES consecutive cycles, starting with the redirect cycle.
- Load-use: exactly 1 stall cycle per hazard occurrence.
- Multiply: the issue cycle advances normally; the next MUL_LATENCY-1 cycles stall. First RUN cycle is MUL_LATENCY cycles after issue.
- A redirect arriving in the last FLUSH cycle or the last MUL_BUSY cycle is ignored. It is accepted on the following RUN cycle if still asserted.
- rst_n rising edge: next cycle is RUN with normal enables.
- Reset asserted mid-FLUSH or mid-MUL_BUSY: abort immediately; no residual flush or hold after release.

## Test plan
- Load-use: EX_mem_read=1, EX_rt_rd=5, ID_rs=5, ID_uses_rs=1 for one cycle → that cycle pc_write_en=0, IF_ID_write_en=0, ID_EX_bubble=1; next cycle enables=1; stall_count=1.
- Redirect with default FLUSH_CYCLES=2: branch_redirect pulse at cycle t → IF_ID_flush=1 at t and t+1, 0 at t+2; pc_write_en=1 throughout; stall_count unchanged.
- Multiply with MUL_LATENCY=4: ID_is_mul at t → EX_hold=1, EX_MEM_bubble=1, pc_write_en=0 at t+1..t+3; RUN at t+4; stall_count=3.
- Priority: branch_redirect, lu and ID_is_mul all high in RUN → flush only, no bubble, no MUL_BUSY entry.
- Redirect held during MUL_BUSY: IF_ID_flush stays 0 until the first RUN cycle, then flush sequence runs.
- Reset: assert rst_n=0 in the 2nd MUL_BUSY cycle → all outputs 0 immediately, stall_count=0; release → normal enables next cycle. Separately, force 65 540 lu cycles → stall_count saturates at 0xFFFF.
